spi_ram_arbiter: RTL
====================

Name: spi_ram_arbiter

Overview:
Two-requester controller that shares one SPI RAM command port (10-bit command word, rx_valid strobe, 8-bit dout, tx_valid). It converts high-level read/write transactions into the RAM's two-word command sequences: a write is {00,addr} then {01,data}; a read is {10,addr} then {11,x}. Requesters are served round-robin, and read data is returned to the requester that issued the read. It sits between the internal requesters and the RAM, where previously the SPI slave alone fed the RAM.

Parameters:
ADDR_SIZE, 8, RAM address width; must equal the RAM's ADDR_SIZE (at most 8, since the command payload is 8 bits).
ADDR_SKIP_EN, 1, when 1, omit the address command if the RAM's internal address register already holds the target address.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has a transaction
req0_ready  output  1  requester 0 transaction accepted this cycle
req0_wr  input  1  1 = write, 0 = read
req0_addr  input  ADDR_SIZE  target address
req0_wdata  input  8  write data (ignored for reads)
rsp0_valid  output  1  one-cycle pulse, read data for requester 0
rsp0_rdata  output  8  read data
req1_valid, req1_ready, req1_wr, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata  same as requester 0, for requester 1
ram_din  output  10  command word to the RAM, {opcode[1:0], payload[7:0]}
ram_rx_valid  output  1  command strobe to the RAM
ram_dout  input  8  RAM read data
ram_tx_valid  input  1  RAM read-data valid

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state goes to IDLE.
  - ram_rx_valid=0, ram_din=0.
  - req*_ready=0, rsp*_valid=0, rsp*_rdata=0.
  - Both address shadows are invalidated.
  - last_grant=1, so requester 0 wins the first tie.
  - Any in-flight transaction is dropped with no response.
- Handshake:
  - reqN_ready is asserted only in IDLE, for the granted requester, in the same cycle as its valid.
  - A transaction transfers when valid & ready.
  - Requesters hold valid and all fields stable until ready.
  - Responses have no backpressure.
- Arbitration:
  - If only one requester is valid, it is granted.
  - If both are valid, the requester not granted last is granted.
  - last_grant updates only on a grant.
- FSM states: IDLE, ADDR, DATA, WAIT.
  - IDLE: on a grant, latch wr, addr, wdata and the requester id. Go to DATA if skip applies, otherwise go to ADDR.
  - ADDR: ram_rx_valid=1, ram_din={00 for write or 10 for read, addr zero-extended}. Set the matching shadow to addr and mark it valid. Go to DATA.
  - DATA (write): ram_rx_valid=1, ram_din={01,wdata}. Go to IDLE.
  - DATA (read): ram_rx_valid=1, ram_din={11,8'h00}. Go to WAIT.
  - WAIT: the RAM registered dout on the previous edge, and ram_tx_valid=1 is required here. Capture ram_dout into rspN_rdata and pulse rspN_valid for one cycle, N being the latched id. Go to IDLE.
- Skip rule: skip applies when ADDR_SKIP_EN=1 and the relevant shadow (write or read) is valid and equals the full-width addr.
- Output timing: ram_din and ram_rx_valid decode only from state and latched registers; there is no combinational path from req* inputs. ram_rx_valid=0 in IDLE and WAIT.
- Latency from accept to completion:
  - write: 2 cycles, or 1 with skip.
  - read: rsp_valid 3 cycles after accept, or 2 with skip.
- Ordering: a new grant is possible in the cycle the FSM is back in IDLE; one transaction is in flight at a time.
- Address boundaries: 0 to 2^ADDR_SIZE-1 with no wrap logic. The shadow compare uses full width, so 0xFF followed by 0x00 always re-issues the address.

Decomposition:
- Package spi_ram_pkg holds:
  - opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11;
  - the state enum ctrl_state_e {IDLE, ADDR, DATA, WAIT}.
- One sub-module, spi_ram_rr_arb: a two-way round-robin grant with a last_grant flop and a grant-enable input.

Test Plan:
- After reset, req0 write addr 0x3C data 0xA5 -> ram_din 0x03C then 0x1A5 on consecutive rx_valid cycles. Then req1 read 0x3C -> 0x23C, 0x300, then rsp1_valid=1 with rsp1_rdata=0xA5, rsp0_valid=0.
- Two writes from req0 to 0x10 (data 0x11 then 0x22) with ADDR_SKIP_EN=1 -> second issues only 0x122. With ADDR_SKIP_EN=0 -> 0x010 is re-issued before 0x122.
- req0 and req1 held valid with reads of 0x01 and 0x02 -> grants alternate 0,1,0,1. Each rsp goes only to its own requester and carries that requester's address data.
- rst=1 during WAIT of a read -> no rsp pulse, ram_rx_valid=0 next cycle. The next read of the same address re-sends {10,addr}.
- Read 0xFF right after reset (RAM also reset) -> 0x2FF, 0x300, rsp rdata=0x00.
- Write 0xFF=0x5A, then write 0x00=0xC3, then read 0xFF and 0x00 -> addresses are re-issued each time and reads return 0x5A and 0xC3.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared opcodes and controller state encoding for the SPI RAM command-port arbiter.
package spi_ram_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    WAIT = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/spi_ram_rr_arb.sv
// Two-way round-robin grant; last_grant remembers the most recent winner.
module spi_ram_rr_arb (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic last_grant;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    gnt0 = en & req0 & (~req1 | last_grant);
    gnt1 = en & req1 & (~req0 | ~last_grant);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (gnt0 | gnt1) begin
      last_grant <= gnt1;
    end
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares one SPI RAM command port between two requesters, expanding each
// read/write into the RAM's two-word command sequence.
module spi_ram_arbiter #(
  parameter int ADDR_SIZE    = 8,
  parameter int ADDR_SKIP_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_wr,
  input  logic [ADDR_SIZE-1:0] req0_addr,
  input  logic [7:0]           req0_wdata,
  output logic                 rsp0_valid,
  output logic [7:0]           rsp0_rdata,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_wr,
  input  logic [ADDR_SIZE-1:0] req1_addr,
  input  logic [7:0]           req1_wdata,
  output logic                 rsp1_valid,
  output logic [7:0]           rsp1_rdata,
  output logic [9:0]           ram_din,
  output logic                 ram_rx_valid,
  input  logic [7:0]           ram_dout,
  input  logic                 ram_tx_valid
);

  import spi_ram_pkg::*;

  ctrl_state_e          state;
  logic                 cur_wr;
  logic                 cur_id;
  logic [ADDR_SIZE-1:0] cur_addr;
  logic [7:0]           cur_wdata;
  logic [ADDR_SIZE-1:0] wr_shadow;
  logic [ADDR_SIZE-1:0] rd_shadow;
  logic                 wr_shadow_vld;
  logic                 rd_shadow_vld;

  logic                 gnt0;
  logic                 gnt1;
  logic                 grant_en;
  logic                 sel_wr;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic [7:0]           sel_wdata;
  logic                 skip;
  logic [7:0]           addr_ext;

  assign grant_en = (state == IDLE) && !rst;

  spi_ram_rr_arb u_arb (
    .clk  (clk),
    .rst  (rst),
    .en   (grant_en),
    .req0 (req0_valid),
    .req1 (req1_valid),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    sel_wr    = gnt1 ? req1_wr    : req0_wr;
    sel_addr  = gnt1 ? req1_addr  : req0_addr;
    sel_wdata = gnt1 ? req1_wdata : req0_wdata;
    skip = (ADDR_SKIP_EN != 0) &&
           (sel_wr ? (wr_shadow_vld && (wr_shadow == sel_addr))
                   : (rd_shadow_vld && (rd_shadow == sel_addr)));
  end

  // RAM-facing outputs decode only from state and latched fields.
  always_comb begin
    addr_ext                  = '0;
    addr_ext[ADDR_SIZE-1:0]   = cur_addr;
    ram_rx_valid              = 1'b0;
    ram_din                   = '0;
    case (state)
      ADDR: begin
        ram_rx_valid = 1'b1;
        ram_din      = {(cur_wr ? OP_WR_ADDR : OP_RD_ADDR), addr_ext};
      end
      DATA: begin
        ram_rx_valid = 1'b1;
        ram_din      = {(cur_wr ? OP_WR_DATA : OP_RD_DATA), (cur_wr ? cur_wdata : 8'h00)};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cur_wr        <= 1'b0;
      cur_id        <= 1'b0;
      cur_addr      <= '0;
      cur_wdata     <= '0;
      wr_shadow     <= '0;
      rd_shadow     <= '0;
      wr_shadow_vld <= 1'b0;
      rd_shadow_vld <= 1'b0;
      rsp0_valid    <= 1'b0;
      rsp1_valid    <= 1'b0;
      rsp0_rdata    <= '0;
      rsp1_rdata    <= '0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt0 | gnt1) begin
            cur_wr    <= sel_wr;
            cur_id    <= gnt1;
            cur_addr  <= sel_addr;
            cur_wdata <= sel_wdata;
            state     <= skip ? DATA : ADDR;
          end
        end
        ADDR: begin
          if (cur_wr) begin
            wr_shadow     <= cur_addr;
            wr_shadow_vld <= 1'b1;
          end else begin
            rd_shadow     <= cur_addr;
            rd_shadow_vld <= 1'b1;
          end
          state <= DATA;
        end
        DATA: state <= cur_wr ? IDLE : WAIT;
        WAIT: begin
          // The RAM registered dout on the edge that closed DATA.
          if (cur_id) begin
            rsp1_valid <= ram_tx_valid;
            if (ram_tx_valid) rsp1_rdata <= ram_dout;
          end else begin
            rsp0_valid <= ram_tx_valid;
            if (ram_tx_valid) rsp0_rdata <= ram_dout;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
